// File: rtl/alu_operand_stage.sv
// ALU operand select with MEM/WB forwarding into one registered valid/ready slot.
// Latency 1 cycle; in_ready = !out_valid || out_ready, outputs frozen while stalled.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        a_sel,
  input  logic [1:0]        b_sel,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_d,
  input  logic [XLEN-1:0]   rs2_d,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
  input  logic              mem_wr_en,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] mem_wr_addr,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [XLEN-1:0]   mem_wr_d,
  input  logic [XLEN-1:0]   wb_wr_d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0]      TAG_NONE  = 2'b00;
  localparam logic [1:0]      TAG_MEM   = 2'b01;
  localparam logic [1:0]      TAG_WB    = 2'b10;
  localparam logic [XLEN-1:0] LP_PC_INC = XLEN'(PC_INC);

  logic            r_vld;
  logic [XLEN-1:0] r_in1;
  logic [XLEN-1:0] r_in2;
  logic [1:0]      r_fwd_a;
  logic [1:0]      r_fwd_b;

  logic            w_accept;
  logic            w_rs1_mem_hit;
  logic            w_rs1_wb_hit;
  logic            w_rs2_mem_hit;
  logic            w_rs2_wb_hit;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [1:0]      w_rs1_tag;
  logic [1:0]      w_rs2_tag;
  logic [XLEN-1:0] w_in1;
  logic [XLEN-1:0] w_in2;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;

  // x0 is hardwired, so a write targeting it must never be bypassed.
  assign w_rs1_mem_hit = mem_wr_en && (mem_wr_addr == rs1_addr) && (rs1_addr != '0);
  assign w_rs1_wb_hit  = wb_wr_en  && (wb_wr_addr  == rs1_addr) && (rs1_addr != '0);
  assign w_rs2_mem_hit = mem_wr_en && (mem_wr_addr == rs2_addr) && (rs2_addr != '0);
  assign w_rs2_wb_hit  = wb_wr_en  && (wb_wr_addr  == rs2_addr) && (rs2_addr != '0);

  always_comb begin
    w_rs1_val = rs1_d;
    w_rs1_tag = TAG_NONE;
    if (w_rs1_mem_hit) begin
      w_rs1_val = mem_wr_d;
      w_rs1_tag = TAG_MEM;
    end else if (w_rs1_wb_hit) begin
      w_rs1_val = wb_wr_d;
      w_rs1_tag = TAG_WB;
    end

    w_rs2_val = rs2_d;
    w_rs2_tag = TAG_NONE;
    if (w_rs2_mem_hit) begin
      w_rs2_val = mem_wr_d;
      w_rs2_tag = TAG_MEM;
    end else if (w_rs2_wb_hit) begin
      w_rs2_val = wb_wr_d;
      w_rs2_tag = TAG_WB;
    end
  end

  always_comb begin
    w_in1   = '0;
    w_fwd_a = TAG_NONE;
    case (a_sel)
      2'b00: begin
        w_in1   = w_rs1_val;
        w_fwd_a = w_rs1_tag;
      end
      2'b01:   w_in1 = pc;
      default: w_in1 = '0;
    endcase

    w_in2   = '0;
    w_fwd_b = TAG_NONE;
    case (b_sel)
      2'b00: begin
        w_in2   = w_rs2_val;
        w_fwd_b = w_rs2_tag;
      end
      2'b01:   w_in2 = imm;
      2'b10:   w_in2 = LP_PC_INC;
      default: w_in2 = '0;
    endcase
  end

  assign in_ready = !r_vld || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 1'b0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_fwd_a <= TAG_NONE;
      r_fwd_b <= TAG_NONE;
    end else if (flush) begin
      r_vld <= 1'b0;
    end else if (w_accept) begin
      r_vld   <= 1'b1;
      r_in1   <= w_in1;
      r_in2   <= w_in2;
      r_fwd_a <= w_fwd_a;
      r_fwd_b <= w_fwd_b;
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign out_valid = r_vld;
  assign alu_in1   = r_in1;
  assign alu_in2   = r_in2;
  assign fwd_a     = r_fwd_a;
  assign fwd_b     = r_fwd_b;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised successor to the single-operand ALU input mux: selects both ALU operands (A from rs1/PC/zero, B from rs2/immediate/PC increment/zero) and resolves read-after-write hazards by forwarding from the MEM and WB stages. Results go into a registered pipeline slot with a valid/ready handshake and synchronous flush. Sits between decode/register-read and the ALU, and holds its operands while the ALU is stalled.

## Interface
- XLEN, 32, datapath width of all operand, PC, immediate and forwarded data
- PC_INC, 4, constant driven on operand B when b_sel selects the increment (JAL/JALR link)
- REG_AW, 5, register-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset: asynchronous assert, active-low
- flush  in  1  synchronous; drops the held slot and any input accepted this cycle
- in_valid  in  1  upstream operand request valid
- in_ready  out  1  stage can accept this cycle
- a_sel  in  2  00 RS1, 01 PC, 10 ZERO, 11 ZERO (reserved)
- b_sel  in  2  00 RS2, 01 IMM, 10 PC_INC, 11 ZERO
- rs1_addr, rs2_addr  in  REG_AW  source register indices
- rs1_d, rs2_d  in  XLEN  register-file read data
- pc, imm  in  XLEN  instruction PC and sign-extended immediate
- mem_wr_en, wb_wr_en  in  1  MEM/WB stage will write a register
- mem_wr_addr, wb_wr_addr  in  REG_AW  destination indices
- mem_wr_d, wb_wr_d  in  XLEN  result data
- out_valid  out  1  alu_in1/alu_in2 hold a valid operand pair
- out_ready  in  1  ALU consumes the pair this cycle
- alu_in1, alu_in2  out  XLEN  registered operands
- fwd_a, fwd_b  out  2  registered source tag per operand: 00 none, 01 MEM, 10 WB

## Operation
- Forwarding applies only when the select picks a register (a_sel=00 / b_sel=00).
- Source resolution for rsN: if mem_wr_en, mem_wr_addr==rsN_addr and rsN_addr!=0, use mem_wr_d (tag 01). Otherwise, if the same test passes for WB, use wb_wr_d (tag 10). Otherwise use rsN_d (tag 00).
- MEM has priority over WB when both match. Register 0 is never forwarded.
- A non-register select always gives tag 00.
- in_ready = !out_valid || out_ready (combinational). No skid buffer.
- accept = in_valid && in_ready && !flush.
- On accept, alu_in1, alu_in2, fwd_a and fwd_b load the resolved values, and out_valid goes to 1.
- Else if out_ready or flush, out_valid goes to 0 and the data registers hold their last value.
- Else all registers hold.
- Flush has priority over accept and over the hold.
- While out_valid && !out_ready, all outputs stay bit-stable.
- Forwarding is evaluated with the bypass inputs present in the accept cycle. Bypass values that arrive while stalled are not re-sampled. Upstream must replay if it needs them.
- Arithmetic: none beyond the equality compares. PC_INC is truncated/zero-extended to XLEN.

## Timing
- Reset (rst_n=0, any time, asynchronous): out_valid=0, alu_in1=0, alu_in2=0, fwd_a=00, fwd_b=00. in_ready reads 1.
- Reset takes effect immediately and drops any held pair.
- Latency: 1 cycle from accept to out_valid=1. Throughput: 1 pair per cycle when out_ready is held at 1.
- Back-to-back: consume and accept in the same cycle replaces the pair, and out_valid stays 1.
- Simultaneous flush with in_valid=1 and in_ready=1: the input is dropped and out_valid=0 next cycle.
- in_ready may depend combinationally on out_ready. There is no path from in_valid to in_ready.

## Test plan
- Reset mid-stream: assert rst_n=0 while out_valid=1 with alu_in1=0x0000000A. Required: outputs go to 0 and out_valid to 0 before the next edge; in_ready=1.
- Plain select, XLEN=32: a_sel=RS1, rs1_d=10; b_sel=IMM, imm=-4. Required: next cycle alu_in1=0x0000000A, alu_in2=0xFFFFFFFC, fwd=00/00. Then a_sel=PC, pc=0xFFFFFFF0, b_sel=PC_INC. Required: alu_in1=0xFFFFFFF0, alu_in2=4.
- Forward priority: rs1_addr=5, MEM writes x5=0x11, WB writes x5=0x22, rs1_d=0x33. Required: alu_in1=0x11, fwd_a=01. With MEM disabled: alu_in1=0x22, fwd_a=10. With rs1_addr=0 and both writing x0: alu_in1=rs1_d, fwd_a=00.
- Forward only on register select: a_sel=PC while MEM matches rs1_addr. Required: alu_in1=pc, fwd_a=00.
- Stall/hold: out_ready=0 for 3 cycles with in_valid=1 and changing inputs. Required: in_ready=0 and outputs frozen. Raising out_ready gives consume and accept in the same cycle, and the new pair appears next cycle.
- Flush: flush=1 in the same cycle as accept with out_valid=1. Required: out_valid=0 next cycle. Also run XLEN=16 with PC_INC=2 and check truncation and forwarding.
